// File: rtl/mul_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states, Booth digit
// selects and the step-count helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_sel_e;

    // Operands are extended by two bits, so one extra digit covers the extension.
    function automatic int steps(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window onto the matching signed
// multiple of the extended multiplicand (0, +-a, +-2a).
module booth_r4_digit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        [2:0]       window,
    input  logic signed [WIDTH+1:0] a_ext,
    output logic signed [WIDTH+2:0] pp
);

    digit_sel_e              sel;
    logic signed [WIDTH+2:0] a_w;

    assign a_w = {a_ext[WIDTH+1], a_ext};

    always_comb begin
        sel = ZERO;
        unique case (window)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end

    always_comb begin
        pp = '0;
        case (sel)
            POS1:    pp = a_w;
            POS2:    pp = a_w <<< 1;
            NEG1:    pp = -a_w;
            NEG2:    pp = -(a_w <<< 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier retiring one digit per cycle, with valid/ready
// handshakes, per-operand signedness and synchronous flush.
module booth_seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int EW    = WIDTH + 2;
    localparam int PW    = WIDTH + 3;
    localparam int AW    = 2 * WIDTH + 4;
    localparam int STEPS = steps(WIDTH);
    localparam int CW    = $clog2(STEPS + 1);

    state_e                state;
    logic        [CW-1:0]  cnt;
    logic signed [EW-1:0]  a_ext;
    logic        [EW-1:0]  b_ext;
    logic signed [AW-1:0]  acc;

    logic        [CW-1:0]  idx;
    logic        [CW:0]    shamt;
    logic        [EW:0]    b_pad;
    logic        [2:0]     window;
    logic signed [PW-1:0]  pp;
    logic signed [AW-1:0]  pp_ext;
    logic signed [AW-1:0]  acc_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Digit i covers multiplier bits 2i+1..2i-1; bit -1 is the appended zero.
    assign idx    = CW'(STEPS) - cnt;
    assign shamt  = {idx, 1'b0};
    assign b_pad  = {b_ext, 1'b0};
    assign window = b_pad[shamt +: 3];

    booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
        .window (window),
        .a_ext  (a_ext),
        .pp     (pp)
    );

    assign pp_ext   = {{(AW-PW){pp[PW-1]}}, pp};
    assign acc_next = acc + (pp_ext <<< shamt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_ext  <= '0;
            b_ext  <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        a_ext <= a_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                        b_ext <= b_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
                        acc   <= '0;
                        cnt   <= CW'(STEPS);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            result <= acc_next[2*WIDTH-1:0];
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Randomised and directed bench for booth_seq_mul (WIDTH = 32) against a
// wide-integer reference product.
module tb_booth_seq_mul;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH / 2 + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               a_signed;
    logic               b_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    booth_seq_mul #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic xs, input logic ys);
        logic signed [127:0] xv;
        logic signed [127:0] yv;
        logic signed [127:0] p;
        xv = xs ? {{96{x[31]}}, x} : {96'b0, x};
        yv = ys ? {{96{y[31]}}, y} : {96'b0, y};
        p  = xv * yv;
        return p[63:0];
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                            input logic xs, input logic ys);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_req", {63'b0, in_ready}, 64'd1);
        a        = x;
        b        = y;
        a_signed = xs;
        b_signed = ys;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [31:0] dir_a  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] dir_b  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    logic        dir_as [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        dir_bs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] dir_p  [4] = '{64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFE_0000_0002};

    initial begin
        int          lat;
        logic [63:0] held;
        logic        seen_valid;
        logic        seen_busy;
        logic [31:0] rx, ry;
        logic        rxs, rys;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready",  {63'b0, in_ready},  64'd1);
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_result",    result,             64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed corner products, including latency from the accepting edge.
        for (int i = 0; i < 4; i++) begin
            start_op(dir_a[i], dir_b[i], dir_as[i], dir_bs[i]);
            wait_done(lat);
            check($sformatf("dir%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("dir%0d_result", i), result, dir_p[i]);
            handshake();
            check($sformatf("dir%0d_idle_after", i), {62'b0, in_ready, out_valid}, 64'd2);
        end

        // Backpressure: DONE holds while out_ready is low.
        start_op(32'd7, 32'd9, 1'b0, 1'b0);
        wait_done(lat);
        held = result;
        check("bp_result", held, 64'd63);
        for (int i = 0; i < 10; i++) begin
            a        = $urandom;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_hold", {result[61:0], out_valid, in_ready}, {held[61:0], 2'b10});
        end
        in_valid = 1'b0;
        handshake();
        check("bp_release", {62'b0, in_ready, out_valid}, 64'd2);
        check("bp_result_kept", result, held);

        // Flush mid-BUSY with a competing request.
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        a        = 32'd11;
        b        = 32'd13;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle", {62'b0, in_ready, out_valid}, 64'd2);
        check("flush_result_kept", result, held);
        seen_valid = 1'b0;
        seen_busy  = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
            if (!in_ready) seen_busy = 1'b1;
        end
        check("flush_no_out_valid", {63'b0, seen_valid}, 64'd0);
        check("flush_req_dropped", {63'b0, seen_busy}, 64'd0);
        start_op(32'd3, 32'd5, 1'b0, 1'b0);
        wait_done(lat);
        check("post_flush_result", result, 64'd15);
        handshake();

        // Asynchronous reset mid-BUSY.
        start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("areset_state", {62'b0, in_ready, out_valid}, 64'd2);
        check("areset_result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("areset_no_out_valid", {63'b0, seen_valid}, 64'd0);

        // Randomised operands and signedness modes.
        for (int n = 0; n < 2000; n++) begin
            rx  = $urandom;
            ry  = $urandom;
            rxs = 1'($urandom_range(0, 1));
            rys = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rx = 32'h8000_0000;
                1: ry = 32'hFFFF_FFFF;
                2: rx = 32'h0;
                default: ;
            endcase
            start_op(rx, ry, rxs, rys);
            wait_done(lat);
            check("rand_latency", 64'(lat), 64'(LAT));
            check($sformatf("rand_result a=%h b=%h as=%0d bs=%0d", rx, ry, rxs, rys),
                  result, ref_mul(rx, ry, rxs, rys));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            handshake();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
